// File: rtl/ha_array_mul_seq_ctrl.sv
// Sequencer for the approximate 8x8 HA-array multiplier core. It accepts operands, sums the four
// compressed rows over 4/ROWS_PER_CYC cycles and returns the product. HA_MUL_BIAS_EN adds a saturating BIAS.
module ha_array_mul_seq_ctrl #(
  parameter int          ROWS_PER_CYC = 1,
  parameter logic [15:0] BIAS         = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_x,
  input  logic [7:0]  in_y,
  output logic [7:0]  mul_x,
  output logic [7:0]  mul_y,
  input  logic [6:0]  ha_b_0,
  input  logic [6:0]  ha_b_1,
  input  logic [6:0]  ha_b_2,
  input  logic [6:0]  ha_b_3,
  input  logic [8:0]  ha_t_0,
  input  logic [8:0]  ha_t_1,
  input  logic [8:0]  ha_t_2,
  input  logic [8:0]  ha_t_3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p,
  output logic        busy
);

  if (!(ROWS_PER_CYC inside {1, 2, 4})) begin : g_bad_rows_per_cyc
    $error("ha_array_mul_seq_ctrl: ROWS_PER_CYC=%0d is illegal (use 1, 2 or 4)", ROWS_PER_CYC);
  end

  // row_cnt walks 0..3 in steps of ROWS_PER_CYC; with 4 rows per cycle the step wraps to 0.
  localparam logic [1:0] CNT_STEP = 2'(ROWS_PER_CYC % 4);
  localparam logic [1:0] CNT_LAST = 2'((4 - ROWS_PER_CYC) % 4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  mul_x_q, mul_x_d;
  logic [7:0]  mul_y_q, mul_y_d;
  logic [15:0] acc_q, acc_d;
  logic [1:0]  row_cnt_q, row_cnt_d;
  logic [15:0] out_p_q, out_p_d;
  logic        out_valid_q, out_valid_d;

  logic [6:0]  ha_b [4];
  logic [8:0]  ha_t [4];
  logic [15:0] row_val [4];
  logic [15:0] grp_sum;
  logic [15:0] acc_sum;
  logic [15:0] p_final;

  assign ha_b[0] = ha_b_0;
  assign ha_b[1] = ha_b_1;
  assign ha_b[2] = ha_b_2;
  assign ha_b[3] = ha_b_3;
  assign ha_t[0] = ha_t_0;
  assign ha_t[1] = ha_t_1;
  assign ha_t[2] = ha_t_2;
  assign ha_t[3] = ha_t_3;

  // Each row resolves its carry vector into a 10-bit value, then takes its 2k column weight.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      row_val[k] = {6'd0, {1'b0, ha_t[k]} + {1'b0, ha_b[k], 2'b00}} << (2 * k);
    end
  end

  always_comb begin
    grp_sum = '0;
    for (int k = 0; k < 4; k++) begin
      if (k >= int'(row_cnt_q) && k < int'(row_cnt_q) + ROWS_PER_CYC) begin
        grp_sum = grp_sum + row_val[k];
      end
    end
  end

  assign acc_sum = acc_q + grp_sum;

`ifdef HA_MUL_BIAS_EN
  logic [16:0] biased_sum;
  assign biased_sum = {1'b0, acc_sum} + {1'b0, BIAS};
  assign p_final    = biased_sum[16] ? 16'hFFFF : biased_sum[15:0];
`else
  localparam logic [15:0] unused_bias = BIAS;
  assign p_final = acc_sum;
`endif

  // NOTE: every next-state signal gets its hold value first, so no path through the case leaves one unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    mul_x_d     = mul_x_q;
    mul_y_d     = mul_y_q;
    acc_d       = acc_q;
    row_cnt_d   = row_cnt_q;
    out_p_d     = out_p_q;
    out_valid_d = out_valid_q;

    if (clr) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      acc_d       = '0;
      row_cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            mul_x_d   = in_x;
            mul_y_d   = in_y;
            acc_d     = '0;
            row_cnt_d = '0;
            state_d   = S_ACC;
          end
        end
        S_ACC: begin
          acc_d     = acc_sum;
          row_cnt_d = row_cnt_q + CNT_STEP;
          if (row_cnt_q == CNT_LAST) begin
            out_p_d     = p_final;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
        default: begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      acc_q       <= '0;
      row_cnt_q   <= '0;
      out_p_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mul_x_q     <= mul_x_d;
      mul_y_q     <= mul_y_d;
      acc_q       <= acc_d;
      row_cnt_q   <= row_cnt_d;
      out_p_q     <= out_p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign out_p     = out_p_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ha_array_mul_seq_ctrl.sv
// Bench for ha_array_mul_seq_ctrl: three instances (1, 2 and 4 rows per cycle) run in lockstep.
// Each instance has a stand-in core, and a scoreboard queue is checked by a per-instance monitor.
module tb_ha_array_mul_seq_ctrl;

  localparam int          N      = 3;
  localparam logic [15:0] BIAS_V = 16'h0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  in_x;
  logic [7:0]  in_y;

  logic        in_ready_w  [N];
  logic        out_valid_w [N];
  logic        busy_w      [N];
  logic [7:0]  mul_x_w     [N];
  logic [7:0]  mul_y_w     [N];
  logic [15:0] out_p_w     [N];

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  logic [N-1:0] orphan_ok = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stand-in core: the directed operands return row vectors matching the approximate core's results,
  // and all other operands return exact half-adder compression of each radix-4 row (the sum is x*y).
  function automatic logic [15:0] stub_row(input logic [7:0] x, input logic [7:0] y, input int k);
    logic [7:0] pp0;
    logic [8:0] pp1;
    logic [8:0] both;
    if (x == 8'd3 && y == 8'd3) return (k < 2) ? {7'd0, 9'd1} : 16'd0;
    if (x == 8'd1 && y == 8'd255) return (k == 0) ? {7'd3, 9'd1} : (k == 3) ? {7'd1, 9'd0} : 16'd0;
    if (x == 8'd2 && y == 8'd1) return 16'd0;
    pp0  = y[2*k]   ? x : 8'd0;
    pp1  = y[2*k+1] ? {x, 1'b0} : 9'd0;
    both = {1'b0, pp0} & pp1;
    return {both[7:1], {1'b0, pp0} ^ pp1};
  endfunction

  function automatic logic [15:0] ref_p(input logic [7:0] x, input logic [7:0] y);
    logic [16:0] p;
    if (x == 8'd3 && y == 8'd3)        p = 17'd5;
    else if (x == 8'd1 && y == 8'd255) p = 17'd269;
    else if (x == 8'd2 && y == 8'd1)   p = 17'd0;
    else                               p = {9'd0, x} * {9'd0, y};
`ifdef HA_MUL_BIAS_EN
    p = p + {1'b0, BIAS_V};
    if (p > 17'h0FFFF) p = 17'h0FFFF;
`endif
    return p[15:0];
  endfunction

  for (genvar i = 0; i < N; i++) begin : g_dut
    localparam int RPC = (i == 0) ? 1 : (i == 1) ? 2 : 4;
    logic [6:0]  hb [4];
    logic [8:0]  ht [4];
    logic [15:0] sb [$];
    logic        prev_v = 1'b0;
    logic        prev_hs = 1'b0;
    logic [15:0] prev_p = '0;

    always_comb begin
      for (int k = 0; k < 4; k++) {hb[k], ht[k]} = stub_row(mul_x_w[i], mul_y_w[i], k);
    end

    ha_array_mul_seq_ctrl #(.ROWS_PER_CYC(RPC), .BIAS(BIAS_V)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .in_valid (in_valid),
      .in_ready (in_ready_w[i]),
      .in_x     (in_x),
      .in_y     (in_y),
      .mul_x    (mul_x_w[i]),
      .mul_y    (mul_y_w[i]),
      .ha_b_0   (hb[0]),
      .ha_b_1   (hb[1]),
      .ha_b_2   (hb[2]),
      .ha_b_3   (hb[3]),
      .ha_t_0   (ht[0]),
      .ha_t_1   (ht[1]),
      .ha_t_2   (ht[2]),
      .ha_t_3   (ht[3]),
      .out_valid(out_valid_w[i]),
      .out_ready(out_ready),
      .out_p    (out_p_w[i]),
      .busy     (busy_w[i])
    );

    always @(negedge clk) begin
      if (!rst_n) begin
        prev_v  <= 1'b0;
        prev_hs <= 1'b0;
      end else begin
        if (prev_hs) begin
          check($sformatf("in_ready_after_hs_rpc%0d", RPC), {31'd0, in_ready_w[i]}, 32'd1);
          check($sformatf("valid_drop_after_hs_rpc%0d", RPC), {31'd0, out_valid_w[i]}, 32'd0);
        end
        if (out_valid_w[i] && !prev_v) begin
          if (sb.size() > 0)
            check($sformatf("latency_rpc%0d", RPC), cyc - accept_cyc, 4 / RPC);
          else if (!orphan_ok[i])
            check($sformatf("unexpected_out_rpc%0d", RPC), {31'd0, out_valid_w[i]}, 32'd0);
        end
        if (out_valid_w[i] && prev_v && !prev_hs)
          check($sformatf("held_p_rpc%0d", RPC), {16'd0, out_p_w[i]}, {16'd0, prev_p});
        if (out_valid_w[i] && out_ready) begin
          if (sb.size() > 0)
            check($sformatf("out_p_rpc%0d", RPC), {16'd0, out_p_w[i]}, {16'd0, sb.pop_front()});
          else
            check($sformatf("hs_without_op_rpc%0d", RPC), {31'd0, out_valid_w[i]}, 32'd0);
        end
        prev_v  <= out_valid_w[i];
        prev_p  <= out_p_w[i];
        prev_hs <= out_valid_w[i] && out_ready;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pending();
    return g_dut[0].sb.size() + g_dut[1].sb.size() + g_dut[2].sb.size();
  endfunction

  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp, input int stall);
    int n;
    n = 0;
    while (!(in_ready_w[0] && in_ready_w[1] && in_ready_w[2]) && n < 50) begin
      step();
      n++;
    end
    if (n == 50) check("idle_timeout", {31'd0, in_ready_w[0] && in_ready_w[1] && in_ready_w[2]}, 32'd1);
    g_dut[0].sb.push_back(exp);
    g_dut[1].sb.push_back(exp);
    g_dut[2].sb.push_back(exp);
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    in_x      = x;
    in_y      = y;
    step();
    accept_cyc = cyc;
    in_valid   = 1'b0;
    in_x       = 8'($urandom);
    in_y       = 8'($urandom);
    n = 0;
    while (pending() > 0 && n < 64) begin
      step();
      n++;
      if (n == stall) out_ready = 1'b1;
    end
    if (n == 64) begin
      check("drain_timeout", pending(), 32'd0);
      g_dut[0].sb.delete();
      g_dut[1].sb.delete();
      g_dut[2].sb.delete();
    end
    out_ready = 1'b1;
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check("rst_in_ready",  {31'd0, in_ready_w[i]},  32'd1);
      check("rst_out_valid", {31'd0, out_valid_w[i]}, 32'd0);
      check("rst_busy",      {31'd0, busy_w[i]},      32'd0);
      check("rst_out_p",     {16'd0, out_p_w[i]},     32'd0);
      check("rst_mul_x",     {24'd0, mul_x_w[i]},     32'd0);
      check("rst_mul_y",     {24'd0, mul_y_w[i]},     32'd0);
    end

    do_op(8'd3,   8'd3,   ref_p(8'd3, 8'd3), 0);
    do_op(8'd1,   8'd255, ref_p(8'd1, 8'd255), 0);
    do_op(8'd2,   8'd1,   ref_p(8'd2, 8'd1), 0);
    do_op(8'd255, 8'd255, ref_p(8'd255, 8'd255), 0);
    do_op(8'd0,   8'd0,   ref_p(8'd0, 8'd0), 0);
`ifdef HA_MUL_BIAS_EN
    do_op(8'd3,   8'd3,   16'h0105, 0);
`else
    do_op(8'd3,   8'd3,   16'd5, 0);
`endif

    // Backpressure: the product is held for 10 cycles while new operands are offered and ignored.
    step();
    g_dut[0].sb.push_back(ref_p(8'd5, 8'd7));
    g_dut[1].sb.push_back(ref_p(8'd5, 8'd7));
    g_dut[2].sb.push_back(ref_p(8'd5, 8'd7));
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_x      = 8'd5;
    in_y      = 8'd7;
    step();
    accept_cyc = cyc;
    in_valid   = 1'b0;
    n = 0;
    while (!out_valid_w[0] && n < 20) begin
      step();
      n++;
    end
    if (n == 20) check("bp_valid_timeout", {31'd0, out_valid_w[0]}, 32'd1);
    in_valid = 1'b1;
    in_x     = 8'd9;
    in_y     = 8'd11;
    repeat (10) begin
      step();
      for (int i = 0; i < N; i++) begin
        check("bp_in_ready_low", {31'd0, in_ready_w[i]},  32'd0);
        check("bp_valid_held",   {31'd0, out_valid_w[i]}, 32'd1);
      end
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b1;
    step();
    step();
    check("bp_single_hs", pending(), 32'd0);
    for (int i = 0; i < N; i++) begin
      check("bp_idle_busy",  {31'd0, busy_w[i]},      32'd0);
      check("bp_idle_valid", {31'd0, out_valid_w[i]}, 32'd0);
    end

    // clr in the second cycle after accept, while in_valid is high.
    out_ready = 1'b0;
    orphan_ok = 3'b100;
    in_valid  = 1'b1;
    in_x      = 8'd7;
    in_y      = 8'd9;
    step();
    in_valid = 1'b0;
    in_x     = 8'd0;
    in_y     = 8'd0;
    step();
    clr      = 1'b1;
    in_valid = 1'b1;
    in_x     = 8'd11;
    in_y     = 8'd13;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      check("clr_busy",      {31'd0, busy_w[i]},      32'd0);
      check("clr_in_ready",  {31'd0, in_ready_w[i]},  32'd1);
      check("clr_out_valid", {31'd0, out_valid_w[i]}, 32'd0);
      check("clr_mul_x",     {24'd0, mul_x_w[i]},     32'd7);
      check("clr_mul_y",     {24'd0, mul_y_w[i]},     32'd9);
    end
    step();
    for (int i = 0; i < N; i++) check("clr_no_accept", {31'd0, busy_w[i]}, 32'd0);
    orphan_ok = '0;
    out_ready = 1'b1;
    do_op(8'd3, 8'd3, ref_p(8'd3, 8'd3), 0);

    for (int t = 0; t < 1000; t++) begin
      logic [7:0] rx;
      logic [7:0] ry;
      rx = 8'($urandom);
      ry = 8'($urandom);
      do_op(rx, ry, ref_p(rx, ry), (t % 5 == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
